// File: rtl/spi_adc_emu_pkg.sv
// Shared FSM encoding and channel-index width helper for the SPI ADC emulator.
package spi_adc_emu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_adc_emu_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin plus one-clk rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  // Reset to the pin's idle level so leaving reset produces no spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

endmodule

// File: rtl/spi_adc_emu.sv
// System-clocked SPI ADC slave emulator (CPHA=0, NUM_CH channels, MSB-first).
// Define SPI_ADC_EMU_CHSEL_EN to let sdi pick the next frame's channel.
module spi_adc_emu
  import spi_adc_emu_pkg::*;
#(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned STEP    = 3,
  parameter int unsigned INIT    = 'h900,
  parameter logic        CPOL    = 1'b0,
  localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csb,
  input  logic              sck,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  input  logic              load_en,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DATA_W-1:0] load_val,
  output logic              frame_done,
  output logic              abort,
  output logic [CH_W-1:0]   cur_ch
);

  localparam int unsigned BC_W = (FRAME_W <= 2) ? 1 : $clog2(FRAME_W);

  state_t              state;
  logic [FRAME_W-1:0]  shreg;
  logic [BC_W-1:0]     bitcnt;
  logic [DATA_W-1:0]   chan [NUM_CH];
  logic [CH_W-1:0]     next_ch;
  logic [FRAME_W-1:0]  frame_word;
  logic                csb_rise, csb_fall, lead, trail;

  spi_sync_edge #(.RST_VAL(1'b1)) u_csb (
    .clk(clk), .reset(reset), .din(csb), .rise(csb_rise), .fall(csb_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .din(sck ^ CPOL), .rise(lead), .fall(trail)
  );

  assign frame_word = FRAME_W'(chan[cur_ch]);

`ifdef SPI_ADC_EMU_CHSEL_EN
  logic               sdi_s1, sdi_s2;
  logic [FRAME_W-1:0] rx;
  logic [FRAME_W-1:0] rx_next;

  assign rx_next = {rx[FRAME_W-2:0], sdi_s2};

  always_ff @(posedge clk) begin
    if (reset) begin
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
      rx     <= '0;
    end else begin
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
      if (state == SHIFT && lead && !csb_rise) rx <= rx_next;
    end
  end

  always_comb begin
    next_ch = '0;
    if (32'(rx_next[CH_W-1:0]) < NUM_CH) next_ch = rx_next[CH_W-1:0];
  end
`else
  logic unused_sdi;
  assign unused_sdi = sdi;

  always_comb begin
    next_ch = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      sdo        <= 1'b0;
      sdo_oe     <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      cur_ch     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) chan[i] <= DATA_W'(INIT);
    end else begin
      frame_done <= 1'b0;
      abort      <= 1'b0;

      if (csb_rise) begin
        sdo    <= 1'b0;
        sdo_oe <= 1'b0;
        bitcnt <= '0;
        state  <= IDLE;
        if (state == SHIFT) abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (csb_fall) begin
              shreg  <= frame_word;
              sdo    <= frame_word[FRAME_W-1];
              sdo_oe <= 1'b1;
              bitcnt <= '0;
              state  <= SHIFT;
            end
          end
          SHIFT: begin
            if (lead) begin
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == BC_W'(FRAME_W - 1)) begin
                chan[cur_ch] <= chan[cur_ch] + DATA_W'(STEP);
                cur_ch       <= next_ch;
                frame_done   <= 1'b1;
                sdo          <= 1'b0;
                state        <= DONE;
              end
            end else if (trail) begin
              shreg <= shreg << 1;
              sdo   <= shreg[FRAME_W-2];
            end
          end
          DONE:    sdo <= 1'b0;
          default: state <= IDLE;
        endcase
      end

      // Placed after the STEP update so a same-cycle load to that channel wins.
      if (load_en && 32'(load_ch) < NUM_CH) chan[load_ch] <= load_val;
    end
  end

endmodule
